// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multi-cycle latency tracker.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RD_SRC_LOAD = 2'b01;

    typedef logic [1:0] mc_state_e;
    localparam mc_state_e MC_IDLE = 2'd0;
    localparam mc_state_e MC_BUSY = 2'd1;
    localparam mc_state_e MC_DONE = 2'd2;

endpackage

// File: rtl/mc_latency_tracker.sv
// Occupancy tracker for the multi-cycle execute unit: holds E for exactly
// the (clamped) latency, then waits in DONE until E is free to advance.
module mc_latency_tracker
    import hazard_pkg::*;
#(
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LAT_W-1:0] lat,
    input  logic             e_adv,
    output logic             mc_stall,
    output logic             busy
);

    mc_state_e        state_reg, state_next;
    logic [LAT_W-1:0] cnt_reg, cnt_next;
    logic [LAT_W-1:0] lat_eff;

    assign lat_eff = (lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mc_stall   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            MC_IDLE: begin
                if (start && lat_eff != '0) begin
                    mc_stall   = 1'b1;
                    busy       = 1'b1;
                    cnt_next   = lat_eff - 1'b1;
                    state_next = (lat_eff > LAT_W'(1)) ? MC_BUSY : MC_DONE;
                end
            end
            MC_BUSY: begin
                // Counts even under a memory stall: the unit runs on its own.
                mc_stall = 1'b1;
                busy     = 1'b1;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= LAT_W'(1)) begin
                    state_next = MC_DONE;
                end
            end
            MC_DONE: begin
                if (e_adv) begin
                    state_next = MC_IDLE;
                end
            end
            default: state_next = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use / multi-cycle /
// memory-wait stalls, branch flush. Counters built only with PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 8,
    parameter int LAT_W      = $clog2(MAX_LAT + 1),
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] D_rs1_addr,
    input  logic [REG_ADDR_W-1:0] D_rs2_addr,
    input  logic                  D_uses_rs1,
    input  logic                  D_uses_rs2,
    input  logic [REG_ADDR_W-1:0] E_rs1_addr,
    input  logic [REG_ADDR_W-1:0] E_rs2_addr,
    input  logic [REG_ADDR_W-1:0] E_rd_addr,
    input  logic [1:0]            E_rd_src_sel,
    input  logic                  E_gpr_wen,
    input  logic [1:0]            E_pc_src_sel,
    input  logic                  E_mc_start,
    input  logic [LAT_W-1:0]      E_mc_lat,
    input  logic [REG_ADDR_W-1:0] M_rd_addr,
    input  logic                  M_gpr_wen,
    input  logic                  M_mem_req,
    input  logic                  M_mem_ready,
    input  logic [REG_ADDR_W-1:0] W_rd_addr,
    input  logic                  W_gpr_wen,
    output logic [1:0]            E_forward_src_a_sel,
    output logic [1:0]            E_forward_src_b_sel,
    output logic                  F_stall_pc,
    output logic                  F_stall_fetch_reg,
    output logic                  D_stall_decode_reg,
    output logic                  E_stall_execute_reg,
    output logic                  M_stall_mem_reg,
    output logic                  F_flush_fetch_reg,
    output logic                  D_flush_decode_reg,
    output logic                  E_flush_execute_reg,
    output logic                  M_flush_mem_reg,
    output logic                  E_mc_busy,
    output logic [PERF_W-1:0]     perf_stall_cycles,
    output logic [PERF_W-1:0]     perf_flush_count
);

    logic [1:0][REG_ADDR_W-1:0] e_src_addr;
    logic [1:0][REG_ADDR_W-1:0] d_src_addr;
    logic [1:0]                 d_uses;
    logic [1:0][1:0]            fwd_sel;
    logic [1:0]                 lu_hit;

    assign e_src_addr = {E_rs2_addr, E_rs1_addr};
    assign d_src_addr = {D_rs2_addr, D_rs1_addr};
    assign d_uses     = {D_uses_rs2, D_uses_rs1};

    // Per-operand forwarding select and load-use match; M wins over W, x0 never forwards.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign fwd_sel[gi] =
                (M_gpr_wen && M_rd_addr != '0 && M_rd_addr == e_src_addr[gi]) ? FWD_M :
                (W_gpr_wen && W_rd_addr != '0 && W_rd_addr == e_src_addr[gi]) ? FWD_W :
                                                                                 FWD_RF;
            assign lu_hit[gi] = d_uses[gi] && (E_rd_addr == d_src_addr[gi]);
        end
    endgenerate

    assign E_forward_src_a_sel = reset ? fwd_sel[0] : FWD_RF;
    assign E_forward_src_b_sel = reset ? fwd_sel[1] : FWD_RF;

    logic mem_stall, mc_stall, lu_stall, mc_busy;
    logic fd_stall, e_stall, branch_adv;

    assign mem_stall = M_mem_req && !M_mem_ready;
    assign lu_stall  = (E_rd_src_sel == RD_SRC_LOAD) && E_gpr_wen &&
                       (E_rd_addr != '0) && (|lu_hit);

    mc_latency_tracker #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_mc_tracker (
        .clk      (clk),
        .reset    (reset),
        .start    (E_mc_start),
        .lat      (E_mc_lat),
        .e_adv    (!mem_stall),
        .mc_stall (mc_stall),
        .busy     (mc_busy)
    );

    assign fd_stall   = mem_stall || mc_stall || lu_stall;
    assign e_stall    = mem_stall || mc_stall;
    // A redirect held in a stalled E flushes only in the cycle it moves on.
    assign branch_adv = (E_pc_src_sel != 2'b00) && !e_stall;

    assign F_stall_pc          = reset && fd_stall;
    assign F_stall_fetch_reg   = reset && fd_stall;
    assign D_stall_decode_reg  = reset && fd_stall;
    assign E_stall_execute_reg = reset && e_stall;
    assign M_stall_mem_reg     = reset && mem_stall;

    assign F_flush_fetch_reg   = !reset || (branch_adv && !fd_stall);
    assign D_flush_decode_reg  = !reset || (branch_adv && !fd_stall);
    assign E_flush_execute_reg = !reset || (lu_stall && !e_stall);
    assign M_flush_mem_reg     = !reset || (mc_stall && !mem_stall);

    assign E_mc_busy = reset && mc_busy;

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_reg;
    logic [PERF_W-1:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (F_stall_pc && perf_stall_reg != '1) begin
                perf_stall_reg <= perf_stall_reg + 1'b1;
            end
            if (F_flush_fetch_reg && perf_flush_reg != '1) begin
                perf_flush_reg <= perf_flush_reg + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_flush_count  = perf_flush_reg;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases followed by
// random stimulus, every cycle compared against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int MAX_LAT    = 8;
    localparam int LAT_W      = $clog2(MAX_LAT + 1);
    localparam int PERF_W     = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REG_ADDR_W-1:0] D_rs1_addr, D_rs2_addr;
    logic                  D_uses_rs1, D_uses_rs2;
    logic [REG_ADDR_W-1:0] E_rs1_addr, E_rs2_addr, E_rd_addr;
    logic [1:0]            E_rd_src_sel;
    logic                  E_gpr_wen;
    logic [1:0]            E_pc_src_sel;
    logic                  E_mc_start;
    logic [LAT_W-1:0]      E_mc_lat;
    logic [REG_ADDR_W-1:0] M_rd_addr;
    logic                  M_gpr_wen, M_mem_req, M_mem_ready;
    logic [REG_ADDR_W-1:0] W_rd_addr;
    logic                  W_gpr_wen;
    logic [1:0]            E_forward_src_a_sel, E_forward_src_b_sel;
    logic                  F_stall_pc, F_stall_fetch_reg, D_stall_decode_reg;
    logic                  E_stall_execute_reg, M_stall_mem_reg;
    logic                  F_flush_fetch_reg, D_flush_decode_reg;
    logic                  E_flush_execute_reg, M_flush_mem_reg;
    logic                  E_mc_busy;
    logic [PERF_W-1:0]     perf_stall_cycles, perf_flush_count;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_LAT    (MAX_LAT),
        .LAT_W      (LAT_W),
        .PERF_W     (PERF_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .D_rs1_addr          (D_rs1_addr),
        .D_rs2_addr          (D_rs2_addr),
        .D_uses_rs1          (D_uses_rs1),
        .D_uses_rs2          (D_uses_rs2),
        .E_rs1_addr          (E_rs1_addr),
        .E_rs2_addr          (E_rs2_addr),
        .E_rd_addr           (E_rd_addr),
        .E_rd_src_sel        (E_rd_src_sel),
        .E_gpr_wen           (E_gpr_wen),
        .E_pc_src_sel        (E_pc_src_sel),
        .E_mc_start          (E_mc_start),
        .E_mc_lat            (E_mc_lat),
        .M_rd_addr           (M_rd_addr),
        .M_gpr_wen           (M_gpr_wen),
        .M_mem_req           (M_mem_req),
        .M_mem_ready         (M_mem_ready),
        .W_rd_addr           (W_rd_addr),
        .W_gpr_wen           (W_gpr_wen),
        .E_forward_src_a_sel (E_forward_src_a_sel),
        .E_forward_src_b_sel (E_forward_src_b_sel),
        .F_stall_pc          (F_stall_pc),
        .F_stall_fetch_reg   (F_stall_fetch_reg),
        .D_stall_decode_reg  (D_stall_decode_reg),
        .E_stall_execute_reg (E_stall_execute_reg),
        .M_stall_mem_reg     (M_stall_mem_reg),
        .F_flush_fetch_reg   (F_flush_fetch_reg),
        .D_flush_decode_reg  (D_flush_decode_reg),
        .E_flush_execute_reg (E_flush_execute_reg),
        .M_flush_mem_reg     (M_flush_mem_reg),
        .E_mc_busy           (E_mc_busy),
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_flush_count    (perf_flush_count)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    // Reference state: stall cycles still owed by the multi-cycle unit, and
    // whether it has finished but waits for E to move on.
    int          mc_left = 0;
    bit          mc_wait = 1'b0;
    logic [31:0] ref_perf_stall = '0;
    logic [31:0] ref_perf_flush = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_ADDR_W-1:0] src);
        if (M_gpr_wen && M_rd_addr != 0 && M_rd_addr == src) return 2'b10;
        if (W_gpr_wen && W_rd_addr != 0 && W_rd_addr == src) return 2'b01;
        return 2'b00;
    endfunction

    // Check the current cycle at the falling edge, then advance the model.
    task automatic step();
        bit          mem, idle, accept, mc, lu, fd, e, br;
        int          lat_c;
        logic [4:0]  exp_stall;
        logic [3:0]  exp_flush;
        logic [1:0]  exp_a, exp_b;
        @(negedge clk);
        mem    = M_mem_req && !M_mem_ready;
        idle   = (mc_left == 0) && !mc_wait;
        lat_c  = (int'(E_mc_lat) > MAX_LAT) ? MAX_LAT : int'(E_mc_lat);
        accept = idle && E_mc_start && lat_c != 0;
        mc     = (mc_left > 0) || accept;
        lu     = (E_rd_src_sel == 2'b01) && E_gpr_wen && E_rd_addr != 0 &&
                 ((D_uses_rs1 && D_rs1_addr == E_rd_addr) || (D_uses_rs2 && D_rs2_addr == E_rd_addr));
        fd     = mem || mc || lu;
        e      = mem || mc;
        br     = (E_pc_src_sel != 0) && !e;
        if (reset) begin
            exp_stall = {fd, fd, fd, e, mem};
            exp_flush = {br && !fd, br && !fd, lu && !e, mc && !mem};
            exp_a     = ref_fwd(E_rs1_addr);
            exp_b     = ref_fwd(E_rs2_addr);
        end else begin
            exp_stall = 5'b00000;
            exp_flush = 4'b1111;
            exp_a     = 2'b00;
            exp_b     = 2'b00;
        end
        check_val("fwd_a", 32'(E_forward_src_a_sel), 32'(exp_a));
        check_val("fwd_b", 32'(E_forward_src_b_sel), 32'(exp_b));
        check_val("stall", 32'({F_stall_pc, F_stall_fetch_reg, D_stall_decode_reg,
                                E_stall_execute_reg, M_stall_mem_reg}), 32'(exp_stall));
        check_val("flush", 32'({F_flush_fetch_reg, D_flush_decode_reg,
                                E_flush_execute_reg, M_flush_mem_reg}), 32'(exp_flush));
        check_val("mc_busy", 32'(E_mc_busy), 32'(reset && mc));
`ifdef PIPELINE_HAZARD_PERF_EN
        check_val("perf_stall", perf_stall_cycles, ref_perf_stall);
        check_val("perf_flush", perf_flush_count, ref_perf_flush);
`else
        check_val("perf_stall", perf_stall_cycles, 32'd0);
        check_val("perf_flush", perf_flush_count, 32'd0);
`endif
        if (!reset) begin
            mc_left        = 0;
            mc_wait        = 1'b0;
            ref_perf_stall = '0;
            ref_perf_flush = '0;
        end else begin
            if (accept) begin
                mc_left = lat_c - 1;
                mc_wait = (mc_left == 0);
            end else if (mc_left > 0) begin
                mc_left--;
                mc_wait = (mc_left == 0);
            end else if (mc_wait && !mem) begin
                mc_wait = 1'b0;
            end
            if (exp_stall[4] && ref_perf_stall != '1) ref_perf_stall++;
            if (exp_flush[3] && ref_perf_flush != '1) ref_perf_flush++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        D_rs1_addr = '0; D_rs2_addr = '0; D_uses_rs1 = 1'b0; D_uses_rs2 = 1'b0;
        E_rs1_addr = '0; E_rs2_addr = '0; E_rd_addr = '0;
        E_rd_src_sel = 2'b00; E_gpr_wen = 1'b0; E_pc_src_sel = 2'b00;
        E_mc_start = 1'b0; E_mc_lat = '0;
        M_rd_addr = '0; M_gpr_wen = 1'b0; M_mem_req = 1'b0; M_mem_ready = 1'b1;
        W_rd_addr = '0; W_gpr_wen = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;
        step(); step();
        reset = 1'b1;
        step();

        // Load-use on rs1
        E_rd_src_sel = 2'b01; E_gpr_wen = 1'b1; E_rd_addr = 5'd5;
        D_rs1_addr = 5'd5; D_uses_rs1 = 1'b1;
        step();
        idle_inputs();
        step();

        // Forwarding priority, then x0
        M_rd_addr = 5'd3; W_rd_addr = 5'd3; M_gpr_wen = 1'b1; W_gpr_wen = 1'b1; E_rs2_addr = 5'd3;
        step();
        M_rd_addr = 5'd0; W_rd_addr = 5'd0; E_rs2_addr = 5'd0;
        step();
        idle_inputs();

        // Multi-cycle latency 4
        E_mc_start = 1'b1; E_mc_lat = 4'd4;
        repeat (5) step();
        idle_inputs();
        step();

        // Branch held behind a memory wait
        E_pc_src_sel = 2'b01; M_mem_req = 1'b1; M_mem_ready = 1'b0;
        repeat (3) step();
        M_mem_ready = 1'b1;
        step();
        idle_inputs();
        step();

        // Reset in the second cycle of a latency-6 operation
        E_mc_start = 1'b1; E_mc_lat = 4'd6;
        step();
        reset = 1'b0;
        step(); step();
        reset = 1'b1; idle_inputs();
        step();

        // Ten load-use stall cycles after a fresh reset
        reset = 1'b0; step(); reset = 1'b1;
        E_rd_src_sel = 2'b01; E_gpr_wen = 1'b1; E_rd_addr = 5'd7;
        D_rs2_addr = 5'd7; D_uses_rs2 = 1'b1;
        repeat (10) step();
        idle_inputs();
        step();
`ifdef PIPELINE_HAZARD_PERF_EN
        check_val("perf_ten_lu", perf_stall_cycles, 32'd10);
`endif

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 59) != 0);
            D_rs1_addr   = REG_ADDR_W'($urandom_range(0, 3));
            D_rs2_addr   = REG_ADDR_W'($urandom_range(0, 3));
            D_uses_rs1   = 1'($urandom_range(0, 1));
            D_uses_rs2   = 1'($urandom_range(0, 1));
            E_rs1_addr   = REG_ADDR_W'($urandom_range(0, 3));
            E_rs2_addr   = REG_ADDR_W'($urandom_range(0, 3));
            E_rd_addr    = REG_ADDR_W'($urandom_range(0, 3));
            E_rd_src_sel = 2'($urandom_range(0, 3));
            E_gpr_wen    = 1'($urandom_range(0, 1));
            E_pc_src_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            E_mc_start   = ($urandom_range(0, 7) == 0);
            E_mc_lat     = LAT_W'($urandom_range(0, 15));
            M_rd_addr    = REG_ADDR_W'($urandom_range(0, 3));
            M_gpr_wen    = 1'($urandom_range(0, 1));
            M_mem_req    = 1'($urandom_range(0, 1));
            M_mem_ready  = ($urandom_range(0, 3) != 0);
            W_rd_addr    = REG_ADDR_W'($urandom_range(0, 3));
            W_gpr_wen    = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the five-stage (F/D/E/M/W) pipeline. Provides forwarding selects, load-use stall, branch flush, a multi-cycle execute-unit occupancy tracker, variable-latency data-memory wait stalls and, optionally, saturating performance counters. Sits beside the controller and datapath in the processor top. It replaces the combinational hazard logic with a unit that holds state across stall cycles.

## Interface
- REG_ADDR_W, 5: register address width.
- MAX_LAT, 8: maximum multi-cycle execute latency, in cycles.
- LAT_W, $clog2(MAX_LAT+1): derived latency field width.
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  clock. One clock domain.
- reset  in  1  synchronous, active-low reset.
- D_rs1_addr, D_rs2_addr  in  REG_ADDR_W each  decode-stage source registers.
- D_uses_rs1, D_uses_rs2  in  1 each  decode instruction actually reads the source.
- E_rs1_addr, E_rs2_addr, E_rd_addr  in  REG_ADDR_W each  execute-stage addresses.
- E_rd_src_sel  in  2  execute rd source; 2'b01 = load data.
- E_gpr_wen  in  1  execute instruction writes rd.
- E_pc_src_sel  in  2  non-zero = redirect taken.
- E_mc_start  in  1  the instruction in E uses the multi-cycle unit.
- E_mc_lat  in  LAT_W  its latency: 0 = single-cycle, valid range 1..MAX_LAT.
- M_rd_addr  in  REG_ADDR_W  memory-stage destination register.
- M_gpr_wen  in  1  memory-stage register write enable.
- M_mem_req  in  1  memory access in M.
- M_mem_ready  in  1  memory response ready.
- W_rd_addr  in  REG_ADDR_W  writeback-stage destination register.
- W_gpr_wen  in  1  writeback-stage register write enable.
- E_forward_src_a_sel, E_forward_src_b_sel  out  2 each  operand forwarding select.
- F_stall_pc, F_stall_fetch_reg, D_stall_decode_reg, E_stall_execute_reg, M_stall_mem_reg  out  1 each  per-stage stall.
- F_flush_fetch_reg, D_flush_decode_reg, E_flush_execute_reg, M_flush_mem_reg  out  1 each  per-stage flush (bubble insert).
- E_mc_busy  out  1  the multi-cycle unit is occupied.
- perf_stall_cycles, perf_flush_count  out  PERF_W each  performance counters.

## Operation
- Forwarding, per operand:
  - 2'b10 when M_gpr_wen, M_rd_addr != 0 and the address matches.
  - Else 2'b01 when W_gpr_wen, W_rd_addr != 0 and the address matches.
  - Else 2'b00.
  - M has priority over W. x0 is never forwarded.
- Stall causes, highest priority first:
  - mem_stall = M_mem_req & !M_mem_ready. Stalls F, D, E and M. Flushes nothing. W continues with the instruction already in it.
  - mc_stall, from the FSM below. Stalls F, D and E. Asserts M_flush_mem_reg.
  - lu_stall = E_rd_src_sel==2'b01 & E_gpr_wen & E_rd_addr!=0 & (the rd matches D rs1 with D_uses_rs1, or D rs2 with D_uses_rs2). Stalls F and D. Asserts E_flush_execute_reg.
- Branch: E_pc_src_sel != 0 asserts F_flush_fetch_reg and D_flush_decode_reg, but only when E is not stalled. A branch held in E flushes once, in the cycle it advances.
- A stall on a stage suppresses that stage's own flush.
- Multi-cycle FSM has three states: MC_IDLE, MC_BUSY, MC_DONE.
  - MC_IDLE:
    - if E_mc_start and E_mc_lat != 0: mc_stall=1 and load cnt=E_mc_lat-1.
    - next state is MC_BUSY if E_mc_lat > 1, else MC_DONE.
  - MC_BUSY:
    - mc_stall=1 and cnt decrements.
    - when cnt==1, go to MC_DONE.
  - MC_DONE:
    - mc_stall=0.
    - return to MC_IDLE on the first cycle E is not stalled by mem_stall. Stay in MC_DONE otherwise.
  - Total mc_stall cycles = E_mc_lat.
- E_mc_busy = 1 in MC_BUSY, and in MC_IDLE when a start is accepted.
- mem_stall during MC_BUSY: cnt keeps counting, because the unit is independent of the pipeline.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the FSM state. There are no registered outputs apart from the counters.
- The FSM and counters update on the rising clk edge.
- When reset==0 at an edge:
  - the FSM goes to MC_IDLE and cnt goes to 0.
  - perf counters go to 0.
- While reset==0:
  - all stalls are 0.
  - all flushes are 1.
  - forwarding selects are 2'b00.
  - E_mc_busy is 0.
- Reset asserted in MC_BUSY abandons the operation. After release the FSM is in MC_IDLE.
- E_mc_lat > MAX_LAT is clamped to MAX_LAT.

## Configuration
- PIPELINE_HAZARD_PERF_EN defined:
  - perf_stall_cycles increments every cycle F_stall_pc=1.
  - perf_flush_count increments every cycle F_flush_fetch_reg=1 while reset==1.
  - both counters saturate at all-ones.
- PIPELINE_HAZARD_PERF_EN undefined: the counter outputs are tied to 0 and no counter flops are built. The ports always exist.

## Structure
- Shared package hazard_pkg holds:
  - fwd_sel_e (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - the RD_SRC_LOAD=2'b01 constant.
  - mc_state_e.
- Sub-module mc_latency_tracker contains the FSM and counter.
  - Inputs: clk, reset, start, lat, e_adv.
  - Outputs: mc_stall, busy.

## Test plan
- E_rd_addr=5 (load, wen), D_rs1_addr=5, D_uses_rs1=1 -> F_stall_pc=1, D_stall_decode_reg=1, E_flush_execute_reg=1 for exactly one cycle.
- M_rd_addr=3 and W_rd_addr=3, both with wen, E_rs2_addr=3 -> E_forward_src_b_sel=2'b10. The same case with address 0 -> 2'b00.
- E_mc_start=1, E_mc_lat=4 -> E_stall_execute_reg high for 4 cycles, M_flush_mem_reg high for 4 cycles, then FSM in MC_IDLE after E advances.
- E_pc_src_sel=2'b01 while M_mem_ready=0 for 3 cycles -> no flush for 3 cycles, F and D flush in the 4th cycle only.
- Reset low in the 2nd cycle of an E_mc_lat=6 operation -> stalls 0 and flushes 1 during reset; after release E_mc_busy=0.
- With PIPELINE_HAZARD_PERF_EN and 10 load-use stalls -> perf_stall_cycles=10.
